// File: rtl/alu_nibble_sequencer_if.sv
// Bundle between the datapath controller, the nibble sequencer and the shared 4-bit alu slice.
// The sequencer takes the slave modport; the controller side (and alu hookup) takes master.
interface alu_nibble_sequencer_if #(
  parameter int NIBBLES = 4
);
  localparam int W = 4 * NIBBLES;

  // Both req and resp use valid/ready: a transfer happens on a rising clk edge where
  // valid && ready; the source holds valid and its payload stable until that edge, and
  // ready never depends on valid (no combinational loop through the handshake).
  logic         req_valid;
  logic         req_ready;
  logic [4:0]   req_op;
  logic [W-1:0] req_a;
  logic [W-1:0] req_b;

  logic [12:0]  alu_args;
  logic [4:0]   alu_ret;

  logic         resp_valid;
  logic         resp_ready;
  logic [W-1:0] resp_res;
  logic         resp_carry;
  logic         resp_ones;
  logic         resp_err;

  modport slave (
    input  req_valid, req_op, req_a, req_b, alu_ret, resp_ready,
    output req_ready, alu_args, resp_valid, resp_res, resp_carry, resp_ones, resp_err
  );

  modport master (
    output req_valid, req_op, req_a, req_b, alu_ret, resp_ready,
    input  req_ready, alu_args, resp_valid, resp_res, resp_carry, resp_ones, resp_err
  );
endinterface

// File: rtl/alu_nibble_sequencer.sv
// Drives a wide operation through a 4-bit alu slice one nibble per clock, chaining carry.
// Define ALU_SEQ_BACK2BACK_EN to accept the next request in the same cycle as a response.
module alu_nibble_sequencer #(
  parameter int NIBBLES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  alu_nibble_sequencer_if.slave bus,
  output logic [1:0]            fsm_state
);
  localparam int W  = 4 * NIBBLES;
  localparam int KW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [KW-1:0] LAST = KW'(NIBBLES - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
  typedef enum logic [1:0] {K_ARITH = 2'd0, K_LOGIC = 2'd1, K_SHIFT = 2'd2, K_ILLEGAL = 2'd3} kind_t;

  state_t         state;
  kind_t          kind_q;
  logic [KW-1:0]  k_q;
  logic [W-1:0]   a_q;
  logic [W-1:0]   b_q;
  logic [W-1:0]   res_q;
  logic [NIBBLES-1:0] cin_q;
  logic [3:0]     ctrl_q;
  logic           b_lsb_q;
  logic           ready_q;
  logic [12:0]    args_q;
  logic           resp_valid_q;
  logic [W-1:0]   resp_res_q;
  logic           resp_carry_q;
  logic           resp_ones_q;
  logic           resp_err_q;

  kind_t              req_kind;
  logic [NIBBLES-1:0] cin_vec;
  logic [12:0]        start_args;
  logic               cin_next;
  logic               carry_last;
  logic [W-1:0]       res_next;
  logic               req_ready_int;
  logic               accept;

  function automatic kind_t classify(input logic [4:0] op);
    if (!op[2]) begin
      return (op[1:0] == 2'b00) ? K_ARITH : K_ILLEGAL;
    end else if (op[1:0] == 2'b11) begin
      return K_SHIFT;
    end
    return K_LOGIC;
  endfunction

  // For RSHFT the carry_in of nibble j is the bit just above it; the top nibble shifts in 0.
  always_comb begin
    cin_vec = '0;
    for (int j = 0; j < NIBBLES - 1; j++) begin
      cin_vec[j] = bus.req_b[4*j + 4];
    end
  end

  always_comb begin
    req_kind   = classify(bus.req_op);
    start_args = '0;
    case (req_kind)
      K_ARITH: start_args = {bus.req_a[3:0], bus.req_b[3:0], bus.req_op[4], bus.req_op[3:0]};
      K_SHIFT: start_args = {bus.req_a[3:0], bus.req_b[3:0], cin_vec[0], bus.req_op[3:0]};
      K_LOGIC: start_args = {bus.req_a[3:0], bus.req_b[3:0], 1'b0, bus.req_op[3:0]};
      default: start_args = '0;
    endcase
  end

  // Operand registers hold the not-yet-issued nibbles at [3:0]; the result fills from the top.
  always_comb begin
    case (kind_q)
      K_ARITH: cin_next = bus.alu_ret[4];
      K_SHIFT: cin_next = cin_q[0];
      default: cin_next = 1'b0;
    endcase
    case (kind_q)
      K_ARITH: carry_last = bus.alu_ret[4];
      K_SHIFT: carry_last = b_lsb_q;
      default: carry_last = 1'b0;
    endcase
    res_next = (res_q >> 4) | (W'(bus.alu_ret[3:0]) << (W - 4));
  end

`ifdef ALU_SEQ_BACK2BACK_EN
  assign req_ready_int = ready_q | ((state == DONE) & bus.resp_ready);
`else
  assign req_ready_int = ready_q;
`endif

  assign accept = bus.req_valid && req_ready_int;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      kind_q       <= K_ARITH;
      k_q          <= '0;
      a_q          <= '0;
      b_q          <= '0;
      res_q        <= '0;
      cin_q        <= '0;
      ctrl_q       <= '0;
      b_lsb_q      <= 1'b0;
      ready_q      <= 1'b0;
      args_q       <= '0;
      resp_valid_q <= 1'b0;
      resp_res_q   <= '0;
      resp_carry_q <= 1'b0;
      resp_ones_q  <= 1'b0;
      resp_err_q   <= 1'b0;
    end else if (accept) begin
      // Accept happens from IDLE, or from DONE together with the response handshake.
      state        <= RUN;
      kind_q       <= req_kind;
      k_q          <= '0;
      a_q          <= bus.req_a >> 4;
      b_q          <= bus.req_b >> 4;
      cin_q        <= cin_vec >> 1;
      ctrl_q       <= bus.req_op[3:0];
      b_lsb_q      <= bus.req_b[0];
      res_q        <= '0;
      ready_q      <= 1'b0;
      args_q       <= start_args;
      resp_valid_q <= 1'b0;
    end else begin
      case (state)
        IDLE: ready_q <= 1'b1;
        RUN: begin
          if (kind_q != K_ILLEGAL) begin
            res_q <= res_next;
          end
          if (k_q == LAST) begin
            state        <= DONE;
            args_q       <= '0;
            resp_valid_q <= 1'b1;
            if (kind_q == K_ILLEGAL) begin
              resp_res_q   <= '0;
              resp_carry_q <= 1'b0;
              resp_ones_q  <= 1'b0;
              resp_err_q   <= 1'b1;
            end else begin
              resp_res_q   <= res_next;
              resp_carry_q <= carry_last;
              resp_ones_q  <= &res_next;
              resp_err_q   <= 1'b0;
            end
          end else begin
            k_q    <= k_q + KW'(1);
            a_q    <= a_q >> 4;
            b_q    <= b_q >> 4;
            cin_q  <= cin_q >> 1;
            args_q <= (kind_q == K_ILLEGAL) ? 13'd0 : {a_q[3:0], b_q[3:0], cin_next, ctrl_q};
          end
        end
        DONE: begin
          if (bus.resp_ready) begin
            state        <= IDLE;
            resp_valid_q <= 1'b0;
            ready_q      <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.req_ready  = req_ready_int;
  assign bus.alu_args   = args_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_res   = resp_res_q;
  assign bus.resp_carry = resp_carry_q;
  assign bus.resp_ones  = resp_ones_q;
  assign bus.resp_err   = resp_err_q;
  assign fsm_state      = state;
endmodule

// File: tb/tb_alu_nibble_sequencer.sv
// Bench for alu_nibble_sequencer (NIBBLES=4) with a behavioural 4-bit alu on alu_args/alu_ret,
// a wide-arithmetic reference model, and directed vectors with literal expectations.
module tb_alu_nibble_sequencer;
  localparam int NIBBLES = 4;
  localparam int W = 4 * NIBBLES;
`ifdef ALU_SEQ_BACK2BACK_EN
  localparam bit B2B = 1'b1;
`else
  localparam bit B2B = 1'b0;
`endif

  localparam logic [4:0] OP_ADD   = 5'b00000;
  localparam logic [4:0] OP_ADDC  = 5'b10000;
  localparam logic [4:0] OP_SUB   = 5'b11000;
  localparam logic [4:0] OP_COMP  = 5'b01000;
  localparam logic [4:0] OP_XOR   = 5'b00100;
  localparam logic [4:0] OP_AND   = 5'b00101;
  localparam logic [4:0] OP_OR    = 5'b00110;
  localparam logic [4:0] OP_XNOR  = 5'b01100;
  localparam logic [4:0] OP_RSHFT = 5'b00111;

  logic       clk;
  logic       rst;
  logic [1:0] fsm_state;
  int         checks;
  int         errors;
  int         cyc;

  alu_nibble_sequencer_if #(.NIBBLES(NIBBLES)) bus ();

  alu_nibble_sequencer #(.NIBBLES(NIBBLES)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .fsm_state (fsm_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- external alu slice ----------------
  function automatic logic [4:0] alu_fn(input logic [12:0] args);
    logic [3:0] d1, d2, bb;
    logic [4:0] ctrl, s;
    d1 = args[12:9];
    d2 = args[8:5];
    ctrl = args[4:0];
    bb = ctrl[3] ? ~d2 : d2;
    if (!ctrl[2]) begin
      s = {1'b0, d1} + {1'b0, bb} + {4'b0, ctrl[4]};
    end else begin
      case (ctrl[1:0])
        2'b00:   s = {1'b0, d1 ^ bb};
        2'b01:   s = {1'b0, d1 & bb};
        2'b10:   s = {1'b0, d1 | bb};
        default: s = {d2[0], ctrl[4], d2[3:1]};
      endcase
    end
    return s;
  endfunction

  assign bus.alu_ret = alu_fn(bus.alu_args);

  // ---------------- reference model: whole-word result ----------------
  // Packed as {res, carry, ones, err}.
  function automatic logic [W+2:0] model(input logic [4:0] op, input logic [W-1:0] a,
                                         input logic [W-1:0] b);
    logic [W-1:0] r, bb;
    logic [W:0]   s;
    logic         c;
    bb = op[3] ? ~b : b;
    c  = 1'b0;
    if (!op[2] && op[1:0] != 2'b00) return {{W{1'b0}}, 1'b0, 1'b0, 1'b1};
    if (!op[2]) begin
      s = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, op[4]};
      r = s[W-1:0];
      c = s[W];
    end else begin
      case (op[1:0])
        2'b00:   r = a ^ bb;
        2'b01:   r = a & bb;
        2'b10:   r = a | bb;
        default: begin r = b >> 1; c = b[0]; end
      endcase
    end
    return {r, c, &r, 1'b0};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- scoreboard / compare process ----------------
  logic [W+2:0] exp_q[$];
  logic [W+2:0] exp_e;
  logic [W+2:0] snap;
  logic [4:0]   cur_op;
  logic [W-1:0] cur_a, cur_b;
  bit           busy, prev_valid, prev_stall;
  int           acc_cyc;
  int           k;

  always @(negedge clk) begin
    if (rst) begin
      chk("reset_outputs", {bus.req_ready, bus.resp_valid, bus.resp_res, bus.resp_carry,
          bus.resp_ones, bus.resp_err, bus.alu_args, fsm_state}, 64'd0);
      exp_q.delete();
      busy = 1'b0;
      prev_valid = 1'b0;
      prev_stall = 1'b0;
    end else begin
      if (prev_stall)
        chk("resp_stable", {bus.resp_valid, bus.resp_res, bus.resp_carry, bus.resp_ones,
            bus.resp_err}, {1'b1, snap});
      if (bus.resp_valid)
        chk("req_ready_in_done", bus.req_ready, B2B ? bus.resp_ready : 1'b0);
      if (busy && (cyc - acc_cyc) < NIBBLES) begin
        k = cyc - acc_cyc;
        if (!cur_op[2] && cur_op[1:0] != 2'b00)
          chk("alu_args_illegal", bus.alu_args, 64'd0);
        else
          chk("alu_args_nibble", {bus.alu_args[12:5], bus.alu_args[3:0]},
              {4'((cur_a >> (4*k))), 4'((cur_b >> (4*k))), cur_op[3:0]});
      end else begin
        chk("alu_args_idle", bus.alu_args, 64'd0);
      end
      if (bus.resp_valid && !prev_valid) begin
        chk("resp_latency", busy ? (cyc - acc_cyc) : -1, NIBBLES);
        busy = 1'b0;
      end
      if (bus.resp_valid && bus.resp_ready) begin
        chk("resp_expected", exp_q.size() != 0, 1'b1);
        if (exp_q.size() != 0) begin
          exp_e = exp_q.pop_front();
          chk("model_res",   bus.resp_res,   exp_e[W+2:3]);
          chk("model_carry", bus.resp_carry, exp_e[2]);
          chk("model_ones",  bus.resp_ones,  exp_e[1]);
          chk("model_err",   bus.resp_err,   exp_e[0]);
        end
      end
      if (bus.req_valid && bus.req_ready) begin
        exp_q.push_back(model(bus.req_op, bus.req_a, bus.req_b));
        cur_op = bus.req_op;
        cur_a = bus.req_a;
        cur_b = bus.req_b;
        acc_cyc = cyc + 1;
        busy = 1'b1;
      end
      prev_valid = bus.resp_valid;
      prev_stall = bus.resp_valid && !bus.resp_ready;
      snap = {bus.resp_res, bus.resp_carry, bus.resp_ones, bus.resp_err};
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_ready();
    int n = 0;
    @(negedge clk);
    while (!bus.req_ready && n < 30) begin
      @(negedge clk);
      n++;
    end
    chk("req_ready_wait", bus.req_ready, 1'b1);
  endtask

  task automatic wait_resp(output int at);
    int n = 0;
    @(negedge clk);
    while (!bus.resp_valid && n < 30) begin
      @(negedge clk);
      n++;
    end
    at = cyc;
    chk("resp_valid_wait", bus.resp_valid, 1'b1);
  endtask

  // Presents a request and returns just after the accepting edge, with req_* scrambled.
  task automatic send(input logic [4:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    bus.req_op = op;
    bus.req_a = a;
    bus.req_b = b;
    bus.req_valid = 1'b1;
    wait_ready();
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    bus.req_op = ~op;
    bus.req_a = ~a;
    bus.req_b = ~b;
  endtask

  task automatic do_op(input string name, input logic [4:0] op, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [W-1:0] e_res, input logic e_c,
                       input logic e_ones, input logic e_err);
    int t;
    send(op, a, b);
    wait_resp(t);
    chk({name, "_res"}, bus.resp_res, e_res);
    chk({name, "_flags"}, {bus.resp_carry, bus.resp_ones, bus.resp_err}, {e_c, e_ones, e_err});
    @(posedge clk);
    #1;
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    int t1, t2;
    checks = 0;
    errors = 0;
    cyc = 0;
    rst = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_op = '0;
    bus.req_a = '0;
    bus.req_b = '0;
    bus.resp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    bus.resp_ready = 1'b1;

    do_op("add_wrap",  OP_ADD,   16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0, 1'b0);
    do_op("sub_borrow", OP_SUB,  16'h1234, 16'h1235, 16'hFFFF, 1'b0, 1'b1, 1'b0);
    do_op("sub_ok",    OP_SUB,   16'h1235, 16'h1234, 16'h0001, 1'b1, 1'b0, 1'b0);
    do_op("comp_eq",   OP_COMP,  16'hA5A5, 16'hA5A5, 16'hFFFF, 1'b0, 1'b1, 1'b0);
    do_op("comp_gt",   OP_COMP,  16'hA5A6, 16'hA5A5, 16'h0000, 1'b1, 1'b0, 1'b0);
    do_op("rshft",     OP_RSHFT, 16'h1234, 16'h8001, 16'h4000, 1'b1, 1'b0, 1'b0);
    do_op("rshft_c4",  OP_RSHFT | 5'b10000, 16'hFFFF, 16'h0003, 16'h0001, 1'b1, 1'b0, 1'b0);
    do_op("rshft_mid", OP_RSHFT, 16'h0000, 16'h0110, 16'h0088, 1'b0, 1'b0, 1'b0);
    do_op("xor",       OP_XOR,   16'hF0F0, 16'hFF00, 16'h0FF0, 1'b0, 1'b0, 1'b0);
    do_op("and",       OP_AND,   16'hF0F0, 16'hFF00, 16'hF000, 1'b0, 1'b0, 1'b0);
    do_op("or",        OP_OR,    16'hF0F0, 16'hFF00, 16'hFFF0, 1'b0, 1'b0, 1'b0);
    do_op("xnor",      OP_XNOR,  16'hF0F0, 16'hFF00, 16'hF00F, 1'b0, 1'b0, 1'b0);
    do_op("addc",      OP_ADDC,  16'h7FFF, 16'h0000, 16'h8000, 1'b0, 1'b0, 1'b0);
    do_op("add_max",   OP_ADD,   16'hFFFF, 16'hFFFF, 16'hFFFE, 1'b1, 1'b0, 1'b0);
    do_op("illegal1",  5'b00001, 16'hFFFF, 16'hFFFF, 16'h0000, 1'b0, 1'b0, 1'b1);
    do_op("illegal2",  5'b11011, 16'h1234, 16'h5678, 16'h0000, 1'b0, 1'b0, 1'b1);

    // Stall on resp_ready=0 for 5 cycles.
    bus.resp_ready = 1'b0;
    send(OP_ADD, 16'h1111, 16'h2222);
    wait_resp(t1);
    repeat (5) begin
      @(negedge clk);
      chk("stall_req_ready", bus.req_ready, 1'b0);
    end
    chk("stall_res", bus.resp_res, 16'h3333);
    @(posedge clk);
    #1;
    bus.resp_ready = 1'b1;
    @(posedge clk);
    #1;

    // Reset in the middle of RUN drops the operation.
    send(OP_ADD, 16'h0F0F, 16'h0101);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("post_rst_req_ready", bus.req_ready, 1'b1);
    chk("post_rst_resp_valid", bus.resp_valid, 1'b0);
    repeat (6) begin
      @(negedge clk);
      chk("post_rst_no_resp", bus.resp_valid, 1'b0);
    end
    @(posedge clk);
    #1;

    // Two queued ADDs: spacing of their responses gives the per-op throughput.
    send(OP_ADD, 16'h0001, 16'h0002);
    bus.req_op = OP_ADD;
    bus.req_a = 16'h1000;
    bus.req_b = 16'h2000;
    bus.req_valid = 1'b1;
    wait_resp(t1);
    chk("first_b2b_res", bus.resp_res, 16'h0003);
    if (!bus.req_ready) wait_ready();
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    wait_resp(t2);
    chk("second_b2b_res", bus.resp_res, 16'h3000);
    chk("throughput", t2 - t1, B2B ? NIBBLES + 1 : NIBBLES + 2);
    @(posedge clk);
    #1;

    repeat (4) @(posedge clk);
    chk("exp_q_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
